// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / no-bypass stall detection, control-flow
// kills, and a data-memory handshake FSM with response timeout and perf counters.
module pipe_hazard_ctrl #(
  parameter int RA_W      = 5,
  parameter int BYPASS_EN = 1,
  parameter int TMO_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  dec_rs1,
  input  logic [RA_W-1:0]  dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [RA_W-1:0]  exe_rd,
  input  logic             exe_rf_wen,
  input  logic             exe_is_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_rf_wen,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_rf_wen,
  input  logic             exe_mem_val,
  input  logic             exe_mem_wr,
  input  logic [1:0]       exe_pc_sel,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  input  logic             dmem_resp_err,
  output logic             dec_stall,
  output logic             full_stall,
  output logic             if_kill,
  output logic             dec_kill,
  output logic             mem_err,
  output logic             tmo_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  // state  | meaning
  // S_IDLE | no memory operation outstanding
  // S_REQ  | request presented, waiting for dmem_req_ready
  // S_WAIT | request accepted, waiting for response or timeout
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Last WAIT cycle: the counter reaches 2^TMO_W-1 as it leaves this cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_t           r_state;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_req_valid;
  logic             r_mem_err;
  logic             r_tmo_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_kill_cnt;

  logic w_in_wait;
  logic w_tmo_hit;
  logic w_mem_done;
  logic w_kill;
  logic w_hit_exe;
  logic w_hit_mem;
  logic w_hit_wb;
  logic w_raw_stall;
  logic w_unused;

  function automatic logic f_match(input logic used, input logic [RA_W-1:0] rs,
                                   input logic [RA_W-1:0] rd, input logic wen);
    return used && (rs == rd) && (rd != '0) && wen;
  endfunction

  // Store vs load does not change the handshake; both wait for a response.
  assign w_unused = exe_mem_wr;

  assign w_in_wait  = (r_state == S_WAIT);
  assign w_tmo_hit  = w_in_wait && (r_tmo_cnt == TMO_LAST);
  assign w_mem_done = w_in_wait && (dmem_resp_valid || w_tmo_hit);
  assign full_stall = exe_mem_val && !w_mem_done;

  assign w_kill   = (exe_pc_sel != 2'b00) && !full_stall;
  assign if_kill  = w_kill;
  assign dec_kill = w_kill;

  assign w_hit_exe = f_match(dec_rs1_used, dec_rs1, exe_rd, exe_rf_wen) ||
                     f_match(dec_rs2_used, dec_rs2, exe_rd, exe_rf_wen);
  assign w_hit_mem = f_match(dec_rs1_used, dec_rs1, mem_rd, mem_rf_wen) ||
                     f_match(dec_rs2_used, dec_rs2, mem_rd, mem_rf_wen);
  assign w_hit_wb  = f_match(dec_rs1_used, dec_rs1, wb_rd, wb_rf_wen) ||
                     f_match(dec_rs2_used, dec_rs2, wb_rd, wb_rf_wen);

  assign w_raw_stall = (BYPASS_EN != 0) ? (exe_is_load && w_hit_exe)
                                        : (w_hit_exe || w_hit_mem || w_hit_wb);
  assign dec_stall   = w_raw_stall && !w_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmo_cnt   <= '0;
      r_req_valid <= 1'b0;
      r_mem_err   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exe_mem_val) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_tmo_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_resp_valid) begin
            r_state   <= S_IDLE;
            r_mem_err <= dmem_resp_err;
          end else if (w_tmo_hit) begin
            r_state   <= S_IDLE;
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase

      if ((dec_stall || full_stall) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_kill && (r_kill_cnt != '1))
        r_kill_cnt <= r_kill_cnt + CNT_W'(1);
    end
  end

  assign dmem_req_valid = r_req_valid;
  assign mem_err        = r_mem_err;
  assign tmo_err        = r_tmo_err;
  assign stall_cnt      = r_stall_cnt;
  assign kill_cnt       = r_kill_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [RA_W-1:0]  dec_rs1, dec_rs2, exe_rd, mem_rd, wb_rd;
  logic             dec_rs1_used, dec_rs2_used, exe_rf_wen, exe_is_load;
  logic             mem_rf_wen, wb_rf_wen, exe_mem_val, exe_mem_wr;
  logic [1:0]       exe_pc_sel;
  logic             dmem_req_ready, dmem_resp_valid, dmem_resp_err;

  logic             dmem_req_valid, dec_stall, full_stall, if_kill, dec_kill;
  logic             mem_err, tmo_err;
  logic [CNT_W-1:0] stall_cnt, kill_cnt;

  logic             nb_dec_stall;
  logic             nb_unused_rv, nb_unused_fs, nb_unused_ik, nb_unused_dk;
  logic             nb_unused_me, nb_unused_te;
  logic [CNT_W-1:0] nb_unused_sc, nb_unused_kc;

  pipe_hazard_ctrl #(.RA_W(RA_W), .BYPASS_EN(1), .TMO_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .exe_rd(exe_rd), .exe_rf_wen(exe_rf_wen), .exe_is_load(exe_is_load),
    .mem_rd(mem_rd), .mem_rf_wen(mem_rf_wen), .wb_rd(wb_rd), .wb_rf_wen(wb_rf_wen),
    .exe_mem_val(exe_mem_val), .exe_mem_wr(exe_mem_wr), .exe_pc_sel(exe_pc_sel),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_err(dmem_resp_err),
    .dec_stall(dec_stall), .full_stall(full_stall),
    .if_kill(if_kill), .dec_kill(dec_kill),
    .mem_err(mem_err), .tmo_err(tmo_err),
    .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  pipe_hazard_ctrl #(.RA_W(RA_W), .BYPASS_EN(0), .TMO_W(2), .CNT_W(CNT_W)) dut_nb (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .exe_rd(exe_rd), .exe_rf_wen(exe_rf_wen), .exe_is_load(exe_is_load),
    .mem_rd(mem_rd), .mem_rf_wen(mem_rf_wen), .wb_rd(wb_rd), .wb_rf_wen(wb_rf_wen),
    .exe_mem_val(exe_mem_val), .exe_mem_wr(exe_mem_wr), .exe_pc_sel(exe_pc_sel),
    .dmem_req_valid(nb_unused_rv), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_err(dmem_resp_err),
    .dec_stall(nb_dec_stall), .full_stall(nb_unused_fs),
    .if_kill(nb_unused_ik), .dec_kill(nb_unused_dk),
    .mem_err(nb_unused_me), .tmo_err(nb_unused_te),
    .stall_cnt(nb_unused_sc), .kill_cnt(nb_unused_kc)
  );

  typedef struct {
    string            nm;
    bit               fs, ds, dsnb, kl, rv, me, te;
    logic [CNT_W-1:0] sc, kc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_sc = 0;
  int   m_kc = 0;

  task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "full_stall", 16'(full_stall), 16'(e.fs));
      chk(e.nm, "dec_stall", 16'(dec_stall), 16'(e.ds));
      chk(e.nm, "dec_stall_nobypass", 16'(nb_dec_stall), 16'(e.dsnb));
      chk(e.nm, "if_kill", 16'(if_kill), 16'(e.kl));
      chk(e.nm, "dec_kill", 16'(dec_kill), 16'(e.kl));
      chk(e.nm, "dmem_req_valid", 16'(dmem_req_valid), 16'(e.rv));
      chk(e.nm, "mem_err", 16'(mem_err), 16'(e.me));
      chk(e.nm, "tmo_err", 16'(tmo_err), 16'(e.te));
      chk(e.nm, "stall_cnt", 16'(stall_cnt), 16'(e.sc));
      chk(e.nm, "kill_cnt", 16'(kill_cnt), 16'(e.kc));
    end
  end

  // Inputs are already set for this cycle; counters shown now reflect earlier cycles.
  task automatic step(input string nm, input bit fs, input bit ds, input bit dsnb,
                      input bit kl, input bit rv, input bit me, input bit te);
    exp_t e;
    bit   r;
    r = rst;
    e.nm = nm; e.fs = fs; e.ds = ds; e.dsnb = dsnb; e.kl = kl;
    e.rv = rv; e.me = me; e.te = te;
    e.sc = CNT_W'(m_sc);
    e.kc = CNT_W'(m_kc);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      m_sc = 0;
      m_kc = 0;
    end else begin
      if ((fs || ds) && m_sc < CMAX) m_sc++;
      if (kl && m_kc < CMAX) m_kc++;
    end
  endtask

  task automatic load_use(input bit on);
    exe_is_load = on; exe_rf_wen = on; exe_rd = 5'd5;
    dec_rs1 = 5'd5; dec_rs1_used = on;
  endtask

  initial begin
    rst = 1'b1;
    dec_rs1 = '0; dec_rs2 = '0; exe_rd = '0; mem_rd = '0; wb_rd = '0;
    dec_rs1_used = 0; dec_rs2_used = 0; exe_rf_wen = 0; exe_is_load = 0;
    mem_rf_wen = 0; wb_rf_wen = 0; exe_mem_val = 0; exe_mem_wr = 0;
    exe_pc_sel = 2'b00; dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_err = 0;
    repeat (2) @(posedge clk);
    #1;

    // combinational outputs follow inputs while in reset
    load_use(1); exe_mem_val = 1;
    step("rst_comb", 1, 1, 1, 0, 0, 0, 0);
    exe_mem_val = 0; exe_pc_sel = 2'b01;
    step("rst_kill", 0, 0, 0, 1, 0, 0, 0);
    rst = 0; exe_pc_sel = 2'b00;

    // stall detection
    step("loaduse", 0, 1, 1, 0, 0, 0, 0);
    exe_rd = 5'd0; dec_rs1 = 5'd0;
    step("rd_zero", 0, 0, 0, 0, 0, 0, 0);
    exe_rd = 5'd5; dec_rs1 = 5'd5; exe_is_load = 0;
    step("no_load", 0, 0, 1, 0, 0, 0, 0);
    exe_is_load = 1; dec_rs1_used = 0;
    step("rs1_unused", 0, 0, 0, 0, 0, 0, 0);
    dec_rs2 = 5'd5; dec_rs2_used = 1; exe_rf_wen = 0;
    step("rs2_wen0", 0, 0, 0, 0, 0, 0, 0);
    exe_rf_wen = 1;
    step("rs2_load", 0, 1, 1, 0, 0, 0, 0);
    exe_is_load = 0; exe_rf_wen = 0; mem_rd = 5'd5; mem_rf_wen = 1;
    step("mem_only", 0, 0, 1, 0, 0, 0, 0);
    mem_rf_wen = 0; wb_rd = 5'd5; wb_rf_wen = 1;
    step("wb_only", 0, 0, 1, 0, 0, 0, 0);
    wb_rf_wen = 0; dec_rs2_used = 0;

    // kill has priority over stall
    load_use(1); exe_pc_sel = 2'b01;
    step("branch_lu", 0, 0, 0, 1, 0, 0, 0);
    load_use(0); exe_pc_sel = 2'b10;
    step("jr", 0, 0, 0, 1, 0, 0, 0);
    exe_pc_sel = 2'b00;

    // minimum-latency memory op, response in second WAIT cycle
    exe_mem_val = 1; dmem_req_ready = 1;
    step("m_idle", 1, 0, 0, 0, 0, 0, 0);
    step("m_req", 1, 0, 0, 0, 1, 0, 0);
    dmem_req_ready = 0; exe_pc_sel = 2'b01;
    step("m_wait1", 1, 0, 0, 0, 0, 0, 0);
    dmem_resp_valid = 1;
    step("m_resp", 0, 0, 0, 1, 0, 0, 0);
    exe_mem_val = 0; dmem_resp_valid = 0; exe_pc_sel = 2'b00;
    step("m_done", 0, 0, 0, 0, 0, 0, 0);
    dmem_resp_valid = 1; dmem_resp_err = 1;
    step("ign_resp", 0, 0, 0, 0, 0, 0, 0);
    dmem_resp_valid = 0; dmem_resp_err = 0;
    step("ign_chk", 0, 0, 0, 0, 0, 0, 0);

    // backpressure, then an error response
    exe_mem_val = 1;
    step("bp_idle", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("bp_hold", 1, 0, 0, 0, 1, 0, 0);
    dmem_req_ready = 1;
    step("bp_rdy", 1, 0, 0, 0, 1, 0, 0);
    dmem_req_ready = 0; dmem_resp_valid = 1; dmem_resp_err = 1;
    step("bp_resp", 0, 0, 0, 0, 0, 0, 0);
    exe_mem_val = 0; dmem_resp_valid = 0; dmem_resp_err = 0;
    step("merr_on", 0, 0, 0, 0, 0, 1, 0);
    step("merr_off", 0, 0, 0, 0, 0, 0, 0);

    // timeout with no response: 3 WAIT cycles
    exe_mem_val = 1; dmem_req_ready = 1;
    step("t_idle", 1, 0, 0, 0, 0, 0, 0);
    step("t_req", 1, 0, 0, 0, 1, 0, 0);
    dmem_req_ready = 0;
    step("t_wait1", 1, 0, 0, 0, 0, 0, 0);
    step("t_wait2", 1, 0, 0, 0, 0, 0, 0);
    step("t_wait3", 0, 0, 0, 0, 0, 0, 0);
    exe_mem_val = 0;
    step("t_after", 0, 0, 0, 0, 0, 0, 1);

    // stall counter saturation, tmo_err stays sticky
    load_use(1);
    for (int i = 0; i < 3; i++) step("sat", 0, 1, 1, 0, 0, 0, 1);
    load_use(0);

    // reset during WAIT abandons the transaction
    exe_mem_val = 1; dmem_req_ready = 1;
    step("r_idle", 1, 0, 0, 0, 0, 0, 1);
    step("r_req", 1, 0, 0, 0, 1, 0, 1);
    dmem_req_ready = 0;
    step("r_wait", 1, 0, 0, 0, 0, 0, 1);
    rst = 1; exe_mem_val = 0;
    step("r_rst", 0, 0, 0, 0, 0, 0, 1);
    rst = 0; dmem_resp_valid = 1; dmem_resp_err = 1;
    step("r_ign", 0, 0, 0, 0, 0, 0, 0);
    dmem_resp_valid = 0; dmem_resp_err = 0;
    step("r_chk", 0, 0, 0, 0, 0, 0, 0);
    exe_mem_val = 1;
    step("r_new", 1, 0, 0, 0, 0, 0, 0);
    step("r_newreq", 1, 0, 0, 0, 1, 0, 0);
    exe_mem_val = 0;

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width.
REQ-002 SHALL have parameter BYPASS_EN, default 1; 1 = full bypass network present, 0 = no bypass.
REQ-003 SHALL have parameter TMO_W, default 4; the response timeout is 2^TMO_W-1 cycles.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have inputs dec_rs1, dec_rs2 (RA_W each) and dec_rs1_used, dec_rs2_used (1 bit each): decode-stage source operands.
REQ-008 SHALL have inputs exe_rd (RA_W), exe_rf_wen (1), exe_is_load (1): execute-stage destination.
REQ-009 SHALL have inputs mem_rd, wb_rd (RA_W each) and mem_rf_wen, wb_rf_wen (1 each): later-stage destinations.
REQ-010 SHALL have inputs exe_mem_val (1), exe_mem_wr (1): execute-stage memory operation, and whether it is a store.
REQ-011 SHALL have input exe_pc_sel (2 bits): 00 = sequential, 01 = branch/jump, 10 = jump-register.
REQ-012 SHALL have output dmem_req_valid (1) and input dmem_req_ready (1): data-memory request handshake.
REQ-013 SHALL have inputs dmem_resp_valid (1), dmem_resp_err (1): data-memory response.
REQ-014 SHALL have outputs dec_stall, full_stall, if_kill, dec_kill (1 each).
REQ-015 SHALL have outputs mem_err (1, one-cycle pulse) and tmo_err (1, sticky).
REQ-016 SHALL have outputs stall_cnt and kill_cnt (CNT_W each).

Function
REQ-017 SHALL implement the memory FSM with states IDLE, REQ, WAIT.
REQ-018 In IDLE with exe_mem_val=1, the FSM SHALL go to REQ.
REQ-019 dmem_req_valid SHALL be 1 in REQ only.
REQ-020 In REQ, the FSM SHALL go to WAIT on dmem_req_ready=1 and otherwise stay in REQ.
REQ-021 In WAIT, the FSM SHALL go to IDLE on dmem_resp_valid=1.
REQ-022 The timeout counter SHALL clear on entry to WAIT, increment each WAIT cycle, and on reaching 2^TMO_W-1 force IDLE and set tmo_err.
REQ-023 full_stall SHALL equal exe_mem_val AND NOT (state==WAIT AND dmem_resp_valid); full_stall is combinational.
REQ-024 A minimum memory operation SHALL take 3 cycles: IDLE, REQ with ready, WAIT with response.
REQ-025 dmem_resp_valid outside WAIT SHALL be ignored and SHALL NOT change state.
REQ-026 mem_err SHALL pulse for one cycle when dmem_resp_valid AND dmem_resp_err in WAIT; the FSM still returns to IDLE.
REQ-027 On timeout, full_stall SHALL deassert in the cycle the FSM forces IDLE, so the pipeline never deadlocks.
REQ-028 Match definition: a source matches a destination when it is used, equal to that rd, that rd is nonzero, and that stage's rf_wen=1.
REQ-029 With BYPASS_EN=1, dec_stall SHALL be 1 iff exe_is_load=1 and either source matches exe_rd (load-use).
REQ-030 With BYPASS_EN=0, dec_stall SHALL be 1 iff either source matches exe_rd, mem_rd or wb_rd.
REQ-031 if_kill and dec_kill SHALL equal (exe_pc_sel != 00) AND NOT full_stall.
REQ-032 When if_kill=1, dec_stall SHALL be forced to 0: kill has priority over stall.
REQ-033 When full_stall=1, dec_stall SHALL still be computed; downstream logic treats full_stall as dominant.
REQ-034 stall_cnt SHALL increment each cycle in which dec_stall OR full_stall is 1, and saturate at all-ones.
REQ-035 kill_cnt SHALL increment each cycle in which if_kill=1, and saturate at all-ones.

Reset
REQ-036 While rst=1: state=IDLE, timeout counter=0, tmo_err=0, mem_err=0, stall_cnt=0, kill_cnt=0, dmem_req_valid=0.
REQ-037 Reset during REQ or WAIT SHALL abandon the transaction; a later dmem_resp_valid in IDLE is ignored.
REQ-038 Combinational outputs (full_stall, dec_stall, kills) SHALL follow their inputs during reset.
REQ-039 tmo_err SHALL clear only on reset.

Verification
REQ-040 Load-use: exe_is_load=1, exe_rf_wen=1, exe_rd=5, dec_rs1=5, rs1_used=1, BYPASS_EN=1 -> dec_stall=1; the same with exe_rd=0 -> dec_stall=0.
REQ-041 Memory, ready immediate, response after 2 WAIT cycles: exe_mem_val=1 -> dmem_req_valid high 1 cycle, full_stall high 3 cycles, low in the response cycle.
REQ-042 Backpressure: dmem_req_ready=0 for 4 cycles -> FSM holds REQ with dmem_req_valid=1; the transition to WAIT occurs on the first ready.
REQ-043 Timeout, TMO_W=2, no response -> after 3 WAIT cycles tmo_err=1, FSM=IDLE, full_stall=0.
REQ-044 Simultaneous branch and load-use: exe_pc_sel=01 with a matching load -> if_kill=dec_kill=1, dec_stall=0, kill_cnt +1.
REQ-045 Reset in WAIT, then dmem_resp_valid=1 in the following IDLE cycle -> no state change, mem_err=0, counters=0.
